bnn_layer_sequencer: RTL and testbench
======================================

// Module: bnn_layer_sequencer
// PURPOSE
//  Top-level run controller for the BNN accelerator: sequences one inference per start edge.
//  Strobes serial conv-kernel weight loads (two 3x3 kernels), launches the conv/pool datapath,
//  streams the FC phase (10 parallel weight lanes), then selects the winning class by serial argmax.
//  Sits between the external weight/image sources and the conv, FC and score datapaths inside top.
// PARAMETERS
//  KERNEL_TAPS  9      serial weight bits per conv kernel
//  FC_LEN       338    FC input beats per run (2 kernels x 13x13 pooled)
//  FC_LAT       2      cycles from last FC beat to stable scores
//  NUM_CLASSES  10     FC output neurons
//  SCORE_W      10     signed score width per class
//  TIMEOUT_CYC  65535  conv_done watchdog limit (only with BNN_SEQ_TIMEOUT_EN)
// PORTS
//  clk          in   1                   clock
//  rstn         in   1                   async active-low reset
//  start        in   1                   run request; rising edge detected internally
//  w_vld        in   1                   conv weight bit available this cycle
//  weight_en_0  out  1                   load-strobe, kernel 0 tap (one bit per w_vld beat)
//  weight_en_1  out  1                   load-strobe, kernel 1 tap
//  conv_start   out  1                   one-cycle pulse launching conv/pool
//  conv_done    in   1                   one-cycle pulse, conv/pool finished
//  fc_ready     in   1                   FC lane accepts a beat
//  fc_ivalid    out  1                   FC beat valid; beat transfers when fc_ivalid&fc_ready
//  scores       in   NUM_CLASSES*SCORE_W class c at [c*SCORE_W +: SCORE_W], signed
//  busy         out  1                   high in any state except IDLE
//  done         out  1                   one-cycle pulse, classes_b valid
//  classes_b    out  4                   winning class index, held until next run's ARGMAX
//  error        out  1                   one-cycle pulse on watchdog abort
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; counters 0; start edge register 0.
//  FSM: IDLE -> LOAD_K0 -> LOAD_K1 -> CONV -> FC -> FC_WAIT -> ARGMAX -> DONE -> IDLE.
//  IDLE: start 0->1 edge enters LOAD_K0 next cycle. Start edges outside IDLE are ignored.
//  LOAD_K0/LOAD_K1: weight_en_x = w_vld (combinational gate from state); tap_cnt++ per beat;
//   after KERNEL_TAPS beats advance. w_vld=0 stalls with strobe low. Exactly 9+9 strobes/run.
//  CONV: conv_start high on first CONV cycle only; wait for conv_done; conv_done in any other
//   state ignored; conv_done coincident with conv_start accepted.
//  FC: fc_ivalid=1 until FC_LEN transfers counted; fc_ready=0 stalls, fc_ivalid stays high.
//   fc_ivalid drops the cycle after the FC_LEN-th transfer.
//  FC_WAIT: FC_LAT cycles, then scores snapshotted into a register array.
//  ARGMAX: one class per cycle, index 0..NUM_CLASSES-1 (10 cycles); replace best only if strictly
//   greater (signed) -> ties resolve to lowest index; classes_b updated at end of ARGMAX.
//  DONE: done=1 for one cycle; back to IDLE. Latency start-edge->done (no stalls, conv_done
//   D cycles after conv_start) = 1+9+9+D+1+338+FC_LAT+10+1.
//  Reset mid-run: immediate return to IDLE, outputs cleared, classes_b cleared to 0.
// CONFIGURATION
//  BNN_SEQ_TIMEOUT_EN defined: CONV counts cycles; reaching TIMEOUT_CYC without conv_done
//   pulses error one cycle, returns to IDLE, classes_b unchanged, no done.
//  Undefined: CONV waits indefinitely; error tied 0; no watchdog counter.
// STRUCTURE
//  bnn_pkg: seq_state_e enum, KERNEL_TAPS/FC_LEN/NUM_CLASSES/SCORE_W defaults, class-index width.
//  Sub-module bnn_argmax_serial: snapshot regs + serial signed compare, start/done handshake.
//  Sequencer keeps FSM, tap/beat/latency counters, start edge detect, optional watchdog.
// TESTING
//  Nominal: start edge, w_vld=1, conv_done 50 cyc after conv_start, fc_ready=1, class 7 max ->
//   9 weight_en_0, 9 weight_en_1, 338 fc_ivalid beats, done once, classes_b=7.
//  Stalls: w_vld and fc_ready random 50% -> still exactly 9+9 strobes, 338 transfers, same result.
//  Tie: scores[2]=scores[5]=+40, others <40 -> classes_b=2; all equal negative -> classes_b=0.
//  Spurious: conv_done during LOAD_K1 and start edge during FC -> both ignored, run completes once.
//  Reset mid-FC (beat 100): busy/fc_ivalid drop immediately; next start runs full 338 beats.
//  BNN_SEQ_TIMEOUT_EN, TIMEOUT_CYC=100, no conv_done -> error pulse at cycle 100 of CONV, no done.

Source files
------------

// File: rtl/bnn_pkg.sv
// Shared types and default sizing for the BNN layer sequencer and its argmax unit.
package bnn_pkg;

    localparam int unsigned KERNEL_TAPS = 9;
    localparam int unsigned FC_LEN      = 338;
    localparam int unsigned FC_LAT      = 2;
    localparam int unsigned NUM_CLASSES = 10;
    localparam int unsigned SCORE_W     = 10;
    localparam int unsigned CLS_W       = $clog2(NUM_CLASSES);

    typedef enum logic [2:0] {
        StIdle,
        StLoadK0,
        StLoadK1,
        StConv,
        StFc,
        StFcWait,
        StArgmax,
        StDone
    } seq_state_e;

endpackage

// File: rtl/bnn_argmax_serial.sv
// Snapshots all class scores on i_start, then scans one class per cycle for the signed maximum.
module bnn_argmax_serial #(
    parameter int unsigned NUM_CLASSES = bnn_pkg::NUM_CLASSES,
    parameter int unsigned SCORE_W     = bnn_pkg::SCORE_W,
    parameter int unsigned CLS_W       = $clog2(NUM_CLASSES)
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           i_start,
    input  logic [NUM_CLASSES*SCORE_W-1:0] i_scores,
    output logic                           o_done,
    output logic [CLS_W-1:0]               o_class
);
    import bnn_pkg::*;

    localparam logic [CLS_W-1:0] LAST_IDX = CLS_W'(NUM_CLASSES - 1);

    logic signed [SCORE_W-1:0] r_snap [NUM_CLASSES];
    logic signed [SCORE_W-1:0] r_best;
    logic        [CLS_W-1:0]   r_best_idx;
    logic        [CLS_W-1:0]   r_idx;
    logic        [CLS_W-1:0]   r_class;
    logic                      r_active;
    logic                      w_take;
    logic        [CLS_W-1:0]   w_win_idx;

    // Strict greater-than keeps the earliest index on ties.
    always_comb begin
        w_take    = (r_idx == '0) || (r_snap[r_idx] > r_best);
        w_win_idx = w_take ? r_idx : r_best_idx;
        o_done    = r_active && (r_idx == LAST_IDX);
        o_class   = r_class;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int c = 0; c < int'(NUM_CLASSES); c++) begin
                r_snap[c] <= '0;
            end
            r_best     <= '0;
            r_best_idx <= '0;
            r_idx      <= '0;
            r_class    <= '0;
            r_active   <= 1'b0;
        end else if (i_start) begin
            for (int c = 0; c < int'(NUM_CLASSES); c++) begin
                r_snap[c] <= i_scores[c*SCORE_W +: SCORE_W];
            end
            r_active <= 1'b1;
            r_idx    <= '0;
        end else if (r_active) begin
            if (w_take) begin
                r_best     <= r_snap[r_idx];
                r_best_idx <= r_idx;
            end
            if (r_idx == LAST_IDX) begin
                r_active <= 1'b0;
                r_class  <= w_win_idx;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/bnn_layer_sequencer.sv
// Run controller: kernel weight loads, conv launch, FC streaming, serial argmax, one run per start.
// Define BNN_SEQ_TIMEOUT_EN to add the conv_done watchdog (TIMEOUT_CYC) and the error pulse.
module bnn_layer_sequencer #(
    parameter int unsigned KERNEL_TAPS = bnn_pkg::KERNEL_TAPS,
    parameter int unsigned FC_LEN      = bnn_pkg::FC_LEN,
    parameter int unsigned FC_LAT      = bnn_pkg::FC_LAT,
    parameter int unsigned NUM_CLASSES = bnn_pkg::NUM_CLASSES,
    parameter int unsigned SCORE_W     = bnn_pkg::SCORE_W,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           start,
    input  logic                           w_vld,
    output logic                           weight_en_0,
    output logic                           weight_en_1,
    output logic                           conv_start,
    input  logic                           conv_done,
    input  logic                           fc_ready,
    output logic                           fc_ivalid,
    input  logic [NUM_CLASSES*SCORE_W-1:0] scores,
    output logic                           busy,
    output logic                           done,
    output logic [3:0]                     classes_b,
    output logic                           error
);
    import bnn_pkg::*;

    localparam int unsigned TAP_W  = $clog2(KERNEL_TAPS + 1);
    localparam int unsigned BEAT_W = $clog2(FC_LEN + 1);
    localparam int unsigned LAT_W  = $clog2(FC_LAT + 1);
    localparam int unsigned CLS_WL = $clog2(NUM_CLASSES);

    seq_state_e              r_state;
    seq_state_e              w_state_next;
    logic                    r_start_q;
    logic [TAP_W-1:0]        r_tap_cnt;
    logic [BEAT_W-1:0]       r_beat_cnt;
    logic [LAT_W-1:0]        r_lat_cnt;
    logic                    r_conv_started;
    logic                    w_am_start;
    logic                    w_am_done;
    logic [CLS_WL-1:0]       w_class;
`ifdef BNN_SEQ_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0]         r_wd_cnt;
`endif

    assign busy      = (r_state != StIdle);
    assign classes_b = 4'(w_class);

    always_comb begin
        w_state_next = r_state;
        weight_en_0  = 1'b0;
        weight_en_1  = 1'b0;
        conv_start   = 1'b0;
        fc_ivalid    = 1'b0;
        done         = 1'b0;
        error        = 1'b0;
        w_am_start   = 1'b0;
        case (r_state)
            StIdle: begin
                if (start && !r_start_q) w_state_next = StLoadK0;
            end
            StLoadK0: begin
                weight_en_0 = w_vld;
                if (w_vld && r_tap_cnt == TAP_W'(KERNEL_TAPS - 1)) w_state_next = StLoadK1;
            end
            StLoadK1: begin
                weight_en_1 = w_vld;
                if (w_vld && r_tap_cnt == TAP_W'(KERNEL_TAPS - 1)) w_state_next = StConv;
            end
            StConv: begin
                conv_start = !r_conv_started;
                if (conv_done) begin
                    w_state_next = StFc;
                end
`ifdef BNN_SEQ_TIMEOUT_EN
                else if (r_wd_cnt == WD_W'(TIMEOUT_CYC - 1)) begin
                    error        = 1'b1;
                    w_state_next = StIdle;
                end
`endif
            end
            StFc: begin
                fc_ivalid = 1'b1;
                if (fc_ready && r_beat_cnt == BEAT_W'(FC_LEN - 1)) w_state_next = StFcWait;
            end
            StFcWait: begin
                if (r_lat_cnt == LAT_W'(FC_LAT - 1)) begin
                    w_am_start   = 1'b1;
                    w_state_next = StArgmax;
                end
            end
            StArgmax: begin
                if (w_am_done) w_state_next = StDone;
            end
            StDone: begin
                done         = 1'b1;
                w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Every per-state counter restarts from zero whenever the state changes.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state        <= StIdle;
            r_start_q      <= 1'b0;
            r_tap_cnt      <= '0;
            r_beat_cnt     <= '0;
            r_lat_cnt      <= '0;
            r_conv_started <= 1'b0;
`ifdef BNN_SEQ_TIMEOUT_EN
            r_wd_cnt       <= '0;
`endif
        end else begin
            r_state   <= w_state_next;
            r_start_q <= start;
            if (w_state_next != r_state) begin
                r_tap_cnt      <= '0;
                r_beat_cnt     <= '0;
                r_lat_cnt      <= '0;
                r_conv_started <= 1'b0;
`ifdef BNN_SEQ_TIMEOUT_EN
                r_wd_cnt       <= '0;
`endif
            end else begin
                case (r_state)
                    StLoadK0, StLoadK1: if (w_vld) r_tap_cnt <= r_tap_cnt + 1'b1;
                    StConv: begin
                        r_conv_started <= 1'b1;
`ifdef BNN_SEQ_TIMEOUT_EN
                        r_wd_cnt       <= r_wd_cnt + 1'b1;
`endif
                    end
                    StFc:     if (fc_ready) r_beat_cnt <= r_beat_cnt + 1'b1;
                    StFcWait: r_lat_cnt <= r_lat_cnt + 1'b1;
                    default: ;
                endcase
            end
        end
    end

    bnn_argmax_serial #(
        .NUM_CLASSES (NUM_CLASSES),
        .SCORE_W     (SCORE_W),
        .CLS_W       (CLS_WL)
    ) u_argmax (
        .clk      (clk),
        .rstn     (rstn),
        .i_start  (w_am_start),
        .i_scores (scores),
        .o_done   (w_am_done),
        .o_class  (w_class)
    );

endmodule

// File: tb/tb_bnn_layer_sequencer.sv
// Self-checking bench for bnn_layer_sequencer: table of score patterns plus hand-built corner runs.
module tb_bnn_layer_sequencer;

    localparam int KT   = 9;
    localparam int FCL  = 338;
    localparam int NVEC = 7;

    logic           clk;
    logic           rstn;
    logic           start;
    logic           w_vld;
    logic           weight_en_0;
    logic           weight_en_1;
    logic           conv_start;
    logic           conv_done;
    logic           fc_ready;
    logic           fc_ivalid;
    logic [99:0]    scores;
    logic           busy;
    logic           done;
    logic [3:0]     classes_b;
    logic           error;

    bnn_layer_sequencer #(
        .TIMEOUT_CYC (100)
    ) u_dut (
        .clk         (clk),
        .rstn        (rstn),
        .start       (start),
        .w_vld       (w_vld),
        .weight_en_0 (weight_en_0),
        .weight_en_1 (weight_en_1),
        .conv_start  (conv_start),
        .conv_done   (conv_done),
        .fc_ready    (fc_ready),
        .fc_ivalid   (fc_ivalid),
        .scores      (scores),
        .busy        (busy),
        .done        (done),
        .classes_b   (classes_b),
        .error       (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0][9:0] sc;
        bit              stall;
        int              d;
        int              exp_cls;
    } vec_t;

    typedef struct {
        int cls;
        int lat;
    } exp_t;

    vec_t tv [NVEC];
    exp_t sb [$];

    int n_vec = 0;
    int n_err = 0;

    // Written by the main sequence only.
    bit stall_mode = 0;
    int cur_d = 50;
    int exp_cls_m = 0;
    int exp_lat_m = 0;
    int req_cnt = 0;
    bit spur_cd_en = 0;
    bit spur_st_en = 0;

    // Written by the driver/monitor only.
    int cyc = 0, served = 0, cd = 0, t0 = 0;
    bit pend_t0 = 0, cd0 = 0, spur_fire = 0, spur_cd_fire = 0;
    int we0 = 0, we1 = 0, xfr = 0, cs_cnt = 0, done_cnt = 0, err_cnt = 0, unexp_done = 0;
    int got_cls = -1, exp_cls_q = -2, got_lat = -1, exp_lat_q = 0, cs_cyc = 0, err_cyc = 0;

    function automatic logic [9:0][9:0] fill(input int base, input int step,
                                             input int hi_idx, input int hi_val);
        logic [9:0][9:0] v;
        for (int c = 0; c < 10; c++) v[c] = 10'(base + c * step);
        v[hi_idx] = 10'(hi_val);
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor at negedge, drive at posedge+1.
    initial begin
        exp_t e;
        start = 1'b0; w_vld = 1'b0; fc_ready = 1'b0; conv_done = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rstn) begin
                sb.delete();
                cd = 0; cd0 = 0; spur_fire = 0; spur_cd_fire = 0;
            end else begin
                if (start && pend_t0) begin t0 = cyc; pend_t0 = 0; end
                if (weight_en_0) we0++;
                if (weight_en_1) begin
                    we1++;
                    if (we1 == KT && cur_d == 0) cd0 = 1;
                    if (we1 == 4 && spur_cd_en) spur_cd_fire = 1;
                end
                if (conv_start) begin
                    cs_cnt++;
                    cs_cyc = cyc;
                    if (cur_d > 0) cd = cur_d;
                end
                if (fc_ivalid && fc_ready) begin
                    xfr++;
                    if (xfr == 100 && spur_st_en) spur_fire = 1;
                end
                if (error) begin err_cnt++; err_cyc = cyc; end
                if (done) begin
                    done_cnt++;
                    if (sb.size() == 0) unexp_done++;
                    else begin
                        e = sb.pop_front();
                        got_cls = int'(classes_b);
                        exp_cls_q = e.cls;
                        got_lat = cyc - t0 + 1;
                        exp_lat_q = e.lat;
                    end
                end
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (req_cnt != served) begin
                start = 1'b1;
                served++;
                we0 = 0; we1 = 0; xfr = 0; cs_cnt = 0;
                e.cls = exp_cls_m;
                e.lat = exp_lat_m;
                sb.push_back(e);
                pend_t0 = 1;
            end else if (spur_fire) begin
                start = 1'b1;
                spur_fire = 0;
            end
            w_vld    = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            fc_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            conv_done = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) conv_done = 1'b1;
            end
            if (cd0) begin conv_done = 1'b1; cd0 = 0; end
            if (spur_cd_fire) begin conv_done = 1'b1; spur_cd_fire = 0; end
        end
    end

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #2;
        end
    endtask

    task automatic launch(input int k);
        scores     = tv[k].sc;
        stall_mode = tv[k].stall;
        cur_d      = tv[k].d;
        exp_cls_m  = tv[k].exp_cls;
        exp_lat_m  = tv[k].stall ? 0 : 371 + tv[k].d;
        req_cnt++;
    endtask

    task automatic run_vec(input int k, input string tag);
        int prev;
        prev = done_cnt;
        launch(k);
        for (int i = 0; i < 6000; i++) begin
            if (done_cnt != prev) break;
            @(negedge clk);
            #2;
        end
        chk({tag, "_done_seen"}, done_cnt - prev, 1);
        chk({tag, "_class"}, got_cls, exp_cls_q);
        if (exp_lat_q != 0) chk({tag, "_latency"}, got_lat, exp_lat_q);
        chk({tag, "_we0_strobes"}, we0, KT);
        chk({tag, "_we1_strobes"}, we1, KT);
        chk({tag, "_conv_starts"}, cs_cnt, 1);
        chk({tag, "_fc_transfers"}, xfr, FCL);
        wait_cycles(6);
        chk({tag, "_done_once"}, done_cnt - prev, 1);
        chk({tag, "_idle_after"}, int'(busy), 0);
        chk({tag, "_class_held"}, int'(classes_b), tv[k].exp_cls);
    endtask

    initial begin
        tv[0] = '{sc: fill(-10, 3, 7, 100),    stall: 0, d: 50, exp_cls: 7};
        tv[1] = '{sc: fill(-10, 3, 7, 100),    stall: 1, d: 20, exp_cls: 7};
        tv[2] = '{sc: fill(-50, 2, 2, 40),     stall: 0, d: 5,  exp_cls: 2};
        tv[2].sc[5] = 10'd40;
        tv[3] = '{sc: fill(-20, 0, 0, -20),    stall: 1, d: 3,  exp_cls: 0};
        tv[4] = '{sc: fill(-300, 5, 9, -1),    stall: 0, d: 0,  exp_cls: 9};
        tv[5] = '{sc: fill(-512, 0, 3, 511),   stall: 1, d: 1,  exp_cls: 3};
        tv[6] = '{sc: fill(-512, 0, 0, -512),  stall: 0, d: 2,  exp_cls: 0};

        scores = '0;
        rstn = 1'b0;
        wait_cycles(3);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_classes_b", int'(classes_b), 0);
        chk("rst_fc_ivalid", int'(fc_ivalid), 0);
        chk("rst_conv_start", int'(conv_start), 0);
        chk("rst_weight_en", int'({weight_en_0, weight_en_1}), 0);
        chk("rst_error", int'(error), 0);
        rstn = 1'b1;
        wait_cycles(2);

        for (int k = 0; k < NVEC; k++) run_vec(k, $sformatf("vec%0d", k));

        // Spurious conv_done in LOAD_K1 and start edge in FC must both be ignored.
        spur_cd_en = 1;
        spur_st_en = 1;
        run_vec(2, "spurious");
        spur_cd_en = 0;
        spur_st_en = 0;

        // Reset at FC beat 100, then a clean full run.
        run_vec(0, "pre_reset");
        launch(0);
        for (int i = 0; i < 2000; i++) begin
            if (xfr >= 100) break;
            @(negedge clk);
            #2;
        end
        chk("reach_beat100", int'(xfr >= 100), 1);
        rstn = 1'b0;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_fc_ivalid", int'(fc_ivalid), 0);
        chk("midrst_classes_b", int'(classes_b), 0);
        wait_cycles(2);
        rstn = 1'b1;
        wait_cycles(2);
        run_vec(0, "post_reset");

`ifdef BNN_SEQ_TIMEOUT_EN
        begin
            int prev_done;
            int prev_err;
            prev_done = done_cnt;
            prev_err  = err_cnt;
            launch(2);
            cur_d = -1;
            for (int i = 0; i < 1000; i++) begin
                if (err_cnt != prev_err) break;
                @(negedge clk);
                #2;
            end
            chk("wd_error_pulse", err_cnt - prev_err, 1);
            chk("wd_error_cycle", err_cyc - cs_cyc + 1, 100);
            wait_cycles(5);
            chk("wd_no_done", done_cnt - prev_done, 0);
            chk("wd_idle", int'(busy), 0);
            chk("wd_classes_kept", int'(classes_b), 7);
        end
`else
        chk("no_error_pulses", err_cnt, 0);
`endif
        chk("unexpected_done", unexp_done, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
